// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and default latencies.
// Hazard control reuses the latency constants to size its stall counting.
package md_pkg;

    typedef logic [2:0] md_op_t;

    typedef enum md_op_t {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // A latency of 1 still needs a one-bit counter.
    function automatic int md_cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if
    import md_pkg::*;
#(
    parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  md_op_t           md_op;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output a, b, md_op, start, input hi, lo, busy, done);
  modport slave  (input a, b, md_op, start, output hi, lo, busy, done);
endinterface

// File: rtl/md_counter.sv
// Loadable down-counter that holds at zero and flags when it gets there.
module md_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (dec && (count_reg != '0))
      count_reg <= count_reg - 1'b1;
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at
// acceptance into a pending register and committed after the op's fixed latency.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic                 clk,
    input logic                 reset,
    mult_div_unit_if.slave      md
);
  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = md_cnt_width(MAX_N);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  md_state_e        state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, lo_reg, pend_hi_reg, pend_lo_reg;
  logic             pend_ok_reg, done_reg;
  logic             cnt_load, cnt_dec, cnt_zero, commit, is_div;
  logic [CW-1:0]    cnt_value;

  md_counter #(.W(CW)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (is_div ? DIV_LOAD : MULT_LOAD),
      .dec      (cnt_dec),
      .count    (cnt_value),
      .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= MD_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    commit     = 1'b0;
    is_div     = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);
    case (state_reg)
      MD_IDLE: begin
        if (md.start && (md.md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})) begin
          state_next = MD_BUSY;
          cnt_load   = 1'b1;
        end
      end
      default: begin
        if (cnt_zero) begin
          commit     = 1'b1;
          state_next = MD_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    endcase
  end

  // Product and quotient/remainder from the live operands; only sampled on acceptance.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   abs_a, abs_b, uq, ur, quot, rem;
  logic               neg_a, neg_b, sgn_div;

  always_comb begin
    a_ext   = (md.md_op == MD_MULT) ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
    b_ext   = (md.md_op == MD_MULT) ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
    prod    = a_ext * b_ext;
    sgn_div = (md.md_op == MD_DIV);
    neg_a   = sgn_div & md.a[WIDTH-1];
    neg_b   = sgn_div & md.b[WIDTH-1];
    abs_a   = neg_a ? -md.a : md.a;
    abs_b   = neg_b ? -md.b : md.b;
    uq      = (abs_b == '0) ? '0 : abs_a / abs_b;
    ur      = (abs_b == '0) ? '0 : abs_a % abs_b;
    quot    = (neg_a ^ neg_b) ? -uq : uq;
    rem     = neg_a ? -ur : ur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_ok_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= commit;
      if (commit && pend_ok_reg) begin
        hi_reg <= pend_hi_reg;
        lo_reg <= pend_lo_reg;
      end
      if ((state_reg == MD_IDLE) && md.start) begin
        case (md.md_op)
          MD_MTHI: hi_reg <= md.a;
          MD_MTLO: lo_reg <= md.a;
          MD_MULT, MD_MULTU: begin
            pend_hi_reg <= prod[2*WIDTH-1:WIDTH];
            pend_lo_reg <= prod[WIDTH-1:0];
            pend_ok_reg <= 1'b1;
          end
          MD_DIV, MD_DIVU: begin
            pend_hi_reg <= rem;
            pend_lo_reg <= quot;
            pend_ok_reg <= (md.b != '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign md.hi   = hi_reg;
  assign md.lo   = lo_reg;
  assign md.busy = (state_reg == MD_BUSY);
  assign md.done = done_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed checks of the multiply/divide unit at 32-bit default latencies and at 16-bit single-cycle latency.
module tb_mult_div_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [15:0] m1_hi = '0, m1_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) i0 ();
  mult_div_unit_if #(.WIDTH(16)) i1 ();

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
      .clk(clk), .reset(rst), .md(i0.slave));
  mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
      .clk(clk), .reset(rst), .md(i1.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input md_op_t op, input logic [31:0] av, input logic [31:0] bv,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input int inj_k, input string tag);
    i0.a = av; i0.b = bv; i0.md_op = op; i0.start = 1'b1;
    @(posedge clk); @(negedge clk);
    i0.start = 1'b0; i0.md_op = MD_NONE; i0.a = 32'h5A5A5A5A; i0.b = 32'h3;
    for (int k = 1; k <= n; k++) begin
      chk({tag, "_busy"}, 64'(i0.busy), 64'd1);
      chk({tag, "_nodone"}, 64'(i0.done), 64'd0);
      chk({tag, "_hold_hi"}, 64'(i0.hi), 64'(m_hi));
      chk({tag, "_hold_lo"}, 64'(i0.lo), 64'(m_lo));
      if (k == inj_k) begin
        i0.start = 1'b1; i0.md_op = MD_MTHI; i0.a = 32'h1234;
      end else begin
        i0.start = 1'b0; i0.md_op = MD_NONE;
      end
      @(negedge clk);
    end
    i0.start = 1'b0; i0.md_op = MD_NONE;
    chk({tag, "_idle"}, 64'(i0.busy), 64'd0);
    chk({tag, "_done"}, 64'(i0.done), 64'd1);
    chk({tag, "_hi"}, 64'(i0.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(i0.lo), 64'(el));
    $display("op %s a=%h b=%h hi=%h lo=%h", tag, av, bv, i0.hi, i0.lo);
    m_hi = eh; m_lo = el;
  endtask

  task automatic run1(input md_op_t op, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] eh, input logic [15:0] el, input string tag);
    i1.a = av; i1.b = bv; i1.md_op = op; i1.start = 1'b1;
    @(posedge clk); @(negedge clk);
    i1.start = 1'b0; i1.md_op = MD_NONE;
    chk({tag, "_busy"}, 64'(i1.busy), 64'd1);
    chk({tag, "_nodone"}, 64'(i1.done), 64'd0);
    chk({tag, "_hold_lo"}, 64'(i1.lo), 64'(m1_lo));
    @(negedge clk);
    chk({tag, "_done"}, 64'(i1.done), 64'd1);
    chk({tag, "_hi"}, 64'(i1.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(i1.lo), 64'(el));
    $display("op %s a=%h b=%h hi=%h lo=%h", tag, av, bv, i1.hi, i1.lo);
    m1_hi = eh; m1_lo = el;
  endtask

  initial begin
    i0.a = '0; i0.b = '0; i0.md_op = MD_NONE; i0.start = 1'b0;
    i1.a = '0; i1.b = '0; i1.md_op = MD_NONE; i1.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(i0.hi), 64'd0);
    chk("rst_lo", 64'(i0.lo), 64'd0);
    chk("rst_busy", 64'(i0.busy), 64'd0);
    chk("rst_done", 64'(i0.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(MD_MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mult");
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 0, "multu");
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 3, "div_mthi_ign");
    run_op(MD_DIVU,  32'd7,        32'd0,        10, m_hi,         m_lo,         0, "divu_by0");
    run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0, "div_ovf");
    run_op(MD_DIVU,  32'hFFFFFFFF, 32'h10,       10, 32'h0000000F, 32'h0FFFFFFF, 0, "divu");

    // mtlo issued in the done cycle
    i0.a = 32'hABCD; i0.md_op = MD_MTLO; i0.start = 1'b1;
    @(posedge clk); @(negedge clk);
    i0.start = 1'b0; i0.md_op = MD_NONE;
    chk("mtlo_lo", 64'(i0.lo), 64'h0000ABCD);
    chk("mtlo_hi", 64'(i0.hi), 64'(m_hi));
    chk("mtlo_busy", 64'(i0.busy), 64'd0);
    chk("mtlo_done", 64'(i0.done), 64'd0);
    $display("op mtlo a=0000abcd lo=%h", i0.lo);
    m_lo = 32'hABCD;

    i0.a = 32'h55; i0.md_op = MD_MTHI; i0.start = 1'b1;
    @(posedge clk); @(negedge clk);
    i0.start = 1'b0; i0.md_op = MD_NONE;
    chk("mthi_hi", 64'(i0.hi), 64'h55);
    chk("mthi_busy", 64'(i0.busy), 64'd0);
    $display("op mthi a=00000055 hi=%h", i0.hi);
    m_hi = 32'h55;

    i0.a = 32'hFFFF; i0.md_op = md_op_t'(3'd7); i0.start = 1'b1;
    @(posedge clk); @(negedge clk);
    i0.start = 1'b0; i0.md_op = MD_NONE;
    chk("op7_hi", 64'(i0.hi), 64'(m_hi));
    chk("op7_lo", 64'(i0.lo), 64'(m_lo));
    chk("op7_busy", 64'(i0.busy), 64'd0);
    $display("op nop7 hi=%h lo=%h", i0.hi, i0.lo);

    // reset in the third busy cycle of a mult
    i0.a = 32'd5; i0.b = 32'd6; i0.md_op = MD_MULT; i0.start = 1'b1;
    @(posedge clk); @(negedge clk);
    i0.start = 1'b0; i0.md_op = MD_NONE;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 64'(i0.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_hi", 64'(i0.hi), 64'd0);
    chk("abort_lo", 64'(i0.lo), 64'd0);
    chk("abort_busy", 64'(i0.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_nodone", 64'(i0.done), 64'd0);
      chk("abort_lo_stays", 64'(i0.lo), 64'd0);
    end
    $display("op reset_abort hi=%h lo=%h", i0.hi, i0.lo);

    run1(MD_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, "w16_div_ovf");
    run1(MD_MULTU, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, "w16_multu");
    run1(MD_MULT,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, "w16_mult");
    run1(MD_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, "w16_div");
    @(negedge clk);
    chk("w16_done_one_cycle", 64'(i1.done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the single-cycle ALU in the execute stage and serves MIPS mult/multu/div/divu/mthi/mtlo. Latency is parametrised, and a busy flag tells hazard control to stall dependent mfhi/mflo and further md ops. Operand width is generic, and HI/LO are each WIDTH bits.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (≥2)
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- a  input  WIDTH  operand (rs); dividend for div; source for mthi/mtlo
- b  input  WIDTH  operand (rt); divisor for div
- md_op  input  3  operation code from shared package
- start  input  1  request strobe, sampled on rising edge
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: HI/LO just committed by mult/div

## Operation
- Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6. Codes 7 and MD_NONE are no-ops.
- Request is accepted only when start=1 and busy=0. A request with busy=1 is ignored; the unit neither queues nor reports it, and hazard control must stall.
- MD_MTHI / MD_MTLO are single-cycle operations:
  - hi (or lo) ← a at the accepting edge.
  - busy and done are not raised.
- mult/multu:
  - Operands are latched at acceptance, so later changes to a/b have no effect.
  - Product is 2·WIDTH bits, signed (mult) or unsigned (multu).
  - hi ← upper WIDTH bits, lo ← lower WIDTH bits.
- div/divu:
  - lo ← quotient, hi ← remainder.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives lo = most-negative and hi = 0.
- Divide by zero (b=0 at acceptance): the full DIV_CYCLES busy period still runs, hi/lo keep their prior values, and done still pulses.
- Two states: IDLE and BUSY, with a down-counter of width clog2(max(MULT_CYCLES, DIV_CYCLES)).
  - IDLE→BUSY on an accepted mult/div: counter ← N−1, where N is the op's cycle count.
  - BUSY with counter>0: decrement.
  - BUSY with counter==0: commit hi/lo, assert done for the next cycle, go to IDLE.
- Result computation may be combinational at acceptance (stored in a pending register) or iterative. Only the commit timing is architectural.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset mid-operation aborts the op: hi/lo return to 0 and nothing commits later.
- Accept at edge E0. busy is high in cycles E0+1 … E0+N (exactly N cycles).
- At edge E0+N, hi/lo update, busy falls, and done rises. done is high for exactly one cycle.
- Back-to-back operation: a new start in the cycle where done=1 (busy=0) is accepted. Minimum issue interval is N+1 cycles.
- mthi/mtlo: the value is visible on hi/lo in the cycle after the accepting edge.
- hi/lo stay stable throughout BUSY (old values). There are no intermediate results on the outputs.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Structure
- Shared package md_pkg holds:
  - MD_* op codes and the 3-bit md_op type
  - default MULT_CYCLES / DIV_CYCLES constants, reused by hazard control for stall counting
- One natural sub-module, md_counter: a parametrised down-counter with load/zero flag. All other logic is flat in mult_div_unit.

## Test plan
- Reset check: after reset, hi=0, lo=0, busy=0. Then MD_MULT, a=−3 (0xFFFFFFFD), b=7 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
- MD_MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 at edge E0+5.
- MD_DIV, a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1) at edge E0+10. MD_DIVU, a=7, b=0 → hi/lo unchanged, busy for 10 cycles, done pulses.
- Busy-period rules:
  - start with MD_MTHI (a=0x1234) during BUSY → ignored, hi unchanged after commit.
  - After completion, MD_MTLO a=0xABCD → lo=0xABCD next cycle, busy stays 0.
- Assert reset at busy cycle 3 of a mult → hi=lo=0, busy=0 immediately, and no done pulse follows.
- Re-parametrise WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=1: div a=0x8000, b=0xFFFF → lo=0x8000, hi=0. Also back-to-back starts accepted every 2 cycles.
